rx_uart: RTL and testbench
==========================

RX_UART -- requirements
Module: rx_uart

Interface
REQ-001 SHALL have parameter N_BITS_DATA, default 8: number of data bits per frame.
REQ-002 SHALL have parameter N_CONT_TICKS, default 4: width of the tick and bit counters.
REQ-003 SHALL have parameter N_BITS_STATE, default 5: width of the one-hot state register.
REQ-004 SHALL have port clock, input, 1: the single clock; all flops are rising-edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port s_ticks, input, 1: one-cycle pulse at 16x the baud rate.
REQ-007 SHALL have port rx_data_in, input, 1: serial line; idles high; asynchronous to clock.
REQ-008 SHALL have port rx_data_out, output, N_BITS_DATA: last correctly framed byte.
REQ-009 SHALL have port rx_done, output, 1: one-cycle pulse; rx_data_out is new.
REQ-010 SHALL have port rx_frame_err, output, 1: one-cycle pulse; the stop bit was sampled low.

Function
REQ-011 SHALL pass rx_data_in through a 2-flop synchronizer (reset value 1) before any use; all "line" references below mean the synchronized value.
REQ-012 SHALL expect this frame format: 1 start bit (0), N_BITS_DATA data bits sent LSB first, 1 parity bit, 1 stop bit (1); each bit lasts 16 ticks.
REQ-013 SHALL use five one-hot states: Idle=00001, Start=00010, Data=00100, Parity=01000, Stop=10000.
REQ-014 SHALL advance the tick counter only on cycles where s_ticks=1; it SHALL hold otherwise and SHALL be cleared in Idle.
REQ-015 Idle: when the line is 0, SHALL go to Start with the tick counter at 0.
REQ-016 Start: on tick count 7 (mid-bit), SHALL clear the tick counter and go to Data if the line is 0; if the line is 1 (a glitch), SHALL return to Idle with no output pulse.
REQ-017 Data: on tick count 15, SHALL shift the line into the MSB of a shift register (a right shift) and increment the bit counter.
REQ-018 Data: after the N_BITS_DATA-th sample, SHALL go to Parity; the byte is then in order, with bit 0 being the first bit received.
REQ-019 Parity: on tick count 15, SHALL capture the parity bit and go to Stop.
REQ-020 Stop: on tick count 15, SHALL sample the line and then go to Idle.
  - Line 1: SHALL load rx_data_out from the shift register and pulse rx_done in the next cycle.
  - Line 0: SHALL pulse rx_frame_err and leave rx_data_out unchanged.
REQ-021 SHALL give rx_done and rx_frame_err exactly 1-cycle width; they SHALL be mutually exclusive.
REQ-022 SHALL hold rx_data_out stable between rx_done pulses.
REQ-023 SHALL accept a new start bit from the first Idle cycle after Stop; back-to-back frames with one stop bit SHALL be received without loss.
REQ-024 SHALL ignore a line 0 seen in any state other than Idle for start detection.
REQ-025 SHALL treat an illegal state encoding as Idle on the next cycle.
REQ-026 The bit counter SHALL wrap only via the clear in Idle; it SHALL never reach 16.

Reset
REQ-027 On reset assertion, SHALL asynchronously set: state=Idle, counters=0, shift register=0, rx_data_out=0, rx_done=0, rx_frame_err=0, synchronizer flops=1.
REQ-028 Reset mid-frame SHALL abort the frame with no output pulse; the next falling line after release SHALL start a fresh frame.

Configuration
REQ-029 With RX_PARITY_CHECK_EN defined, SHALL add output rx_parity_err (1 bit, reset 0).
REQ-030 With RX_PARITY_CHECK_EN defined, rx_parity_err SHALL pulse for 1 cycle alongside rx_done when the captured parity bit differs from the XOR of the data bits (even parity).
REQ-031 With RX_PARITY_CHECK_EN defined, rx_data_out SHALL still update on a parity error.
REQ-032 Without RX_PARITY_CHECK_EN, the port SHALL be absent and the parity bit SHALL be sampled and discarded.

Structure
REQ-033 Package uart_pkg SHALL hold the state encodings, COUNT_READ_DATA=16, the mid-bit count 7, and the data-bit and frame-length constants; it SHALL be shared with the transmitter.
REQ-034 The synchronizer SHALL be a sub-module named sync_2ff; all other logic SHALL be inline.

Verification
REQ-035 The bench SHALL drive s_ticks as 1 pulse every 4 clocks, with frame bits 64 clocks long.
REQ-036 Frame 0xA5, parity 0, stop 1 -> rx_done pulses once, rx_data_out=0xA5, rx_frame_err=0.
REQ-037 Line low for 5 ticks, then high -> state returns to Idle, no pulses, rx_data_out unchanged.
REQ-038 Frame 0x3C with stop bit 0 -> rx_frame_err pulses once, rx_done=0, rx_data_out keeps its previous value.
REQ-039 Frames 0x01 then 0xFF back-to-back -> two rx_done pulses, carrying 0x01 then 0xFF.
REQ-040 Reset asserted mid Data after 3 bits -> all outputs 0 immediately; a following 0x5A frame is received correctly.
REQ-041 With RX_PARITY_CHECK_EN: 0x07 with parity 0 -> rx_done and rx_parity_err both pulse; 0x07 with parity 1 -> rx_done pulses, rx_parity_err=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot state encodings, tick/bit counts and frame geometry.
// Used by both the receiver and the transmitter.
package uart_pkg;

   typedef enum logic [4:0] {
      ST_IDLE   = 5'b00001,
      ST_START  = 5'b00010,
      ST_DATA   = 5'b00100,
      ST_PARITY = 5'b01000,
      ST_STOP   = 5'b10000
   } uart_state_t;

   localparam int unsigned COUNT_READ_DATA = 16;
   localparam int unsigned COUNT_MID_BIT   = 7;
   localparam int unsigned DATA_BITS       = 8;
   localparam int unsigned FRAME_BITS      = 1 + DATA_BITS + 1 + 1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to 1 (idle line level).
module sync_2ff (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rx_uart.sv
// UART receiver: 16x oversampled, start / N data (LSB first) / parity / stop frame.
// Define RX_PARITY_CHECK_EN to add the rx_parity_err output (even parity check).
module rx_uart
   import uart_pkg::*;
#(
   parameter int N_BITS_DATA  = 8,
   parameter int N_CONT_TICKS = 4,
   parameter int N_BITS_STATE = 5
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   s_ticks,
   input  logic                   rx_data_in,
   output logic [N_BITS_DATA-1:0] rx_data_out,
   output logic                   rx_done,
   output logic                   rx_frame_err
`ifdef RX_PARITY_CHECK_EN
   ,
   output logic                   rx_parity_err
`endif
);

   if (N_BITS_STATE != $bits(uart_state_t)) begin : g_state_width_check
      $error("rx_uart: N_BITS_STATE must match the one-hot state encoding width");
   end

   localparam logic [N_CONT_TICKS-1:0] MID_TICK  = N_CONT_TICKS'(COUNT_MID_BIT);
   localparam logic [N_CONT_TICKS-1:0] LAST_TICK = N_CONT_TICKS'(COUNT_READ_DATA - 1);
   localparam logic [N_CONT_TICKS-1:0] LAST_BIT  = N_CONT_TICKS'(N_BITS_DATA - 1);

   logic line;

   sync_2ff u_sync (
      .clock (clock),
      .reset (reset),
      .d     (rx_data_in),
      .q     (line)
   );

   uart_state_t             state_q, state_d;
   logic [N_CONT_TICKS-1:0] tick_q, tick_d;
   logic [N_CONT_TICKS-1:0] bit_q, bit_d;
   logic [N_BITS_DATA-1:0]  shift_q, shift_d;
   logic [N_BITS_DATA-1:0]  data_d;
   logic                    done_d, ferr_d;
`ifdef RX_PARITY_CHECK_EN
   logic                    parity_q, parity_d;
   logic                    perr_d;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         tick_q       <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         rx_data_out  <= '0;
         rx_done      <= 1'b0;
         rx_frame_err <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
         parity_q      <= 1'b0;
         rx_parity_err <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         tick_q       <= tick_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         rx_data_out  <= data_d;
         rx_done      <= done_d;
         rx_frame_err <= ferr_d;
`ifdef RX_PARITY_CHECK_EN
         parity_q      <= parity_d;
         rx_parity_err <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = rx_data_out;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
`ifdef RX_PARITY_CHECK_EN
      parity_d = parity_q;
      perr_d   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            tick_d = '0;
            bit_d  = '0;
            if (!line) state_d = ST_START;
         end
         ST_START: begin
            if (s_ticks) begin
               if (tick_q == MID_TICK) begin
                  // a high line at mid start bit is a glitch, not a frame
                  tick_d  = '0;
                  state_d = line ? ST_IDLE : ST_DATA;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (s_ticks) begin
               if (tick_q == LAST_TICK) begin
                  tick_d  = '0;
                  shift_d = {line, shift_q[N_BITS_DATA-1:1]};
                  bit_d   = bit_q + 1'b1;
                  if (bit_q == LAST_BIT) state_d = ST_PARITY;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (s_ticks) begin
               if (tick_q == LAST_TICK) begin
                  tick_d  = '0;
                  state_d = ST_STOP;
`ifdef RX_PARITY_CHECK_EN
                  parity_d = line;
`endif
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (s_ticks) begin
               if (tick_q == LAST_TICK) begin
                  tick_d  = '0;
                  state_d = ST_IDLE;
                  if (line) begin
                     data_d = shift_q;
                     done_d = 1'b1;
`ifdef RX_PARITY_CHECK_EN
                     perr_d = parity_q ^ (^shift_q);
`endif
                  end else begin
                     ferr_d = 1'b1;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_rx_uart.sv
// Directed bench for rx_uart: table of frames plus glitch, back-to-back and mid-frame reset sequences.
// Define RX_PARITY_CHECK_EN to also check rx_parity_err.
module tb_rx_uart;
   import uart_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic       s_ticks;
   logic       rx_data_in;
   logic [7:0] rx_data_out;
   logic       rx_done;
   logic       rx_frame_err;
`ifdef RX_PARITY_CHECK_EN
   logic       rx_parity_err;
`endif

   rx_uart #(
      .N_BITS_DATA  (DATA_BITS),
      .N_CONT_TICKS (4),
      .N_BITS_STATE (5)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .s_ticks      (s_ticks),
      .rx_data_in   (rx_data_in),
      .rx_data_out  (rx_data_out),
      .rx_done      (rx_done),
      .rx_frame_err (rx_frame_err)
`ifdef RX_PARITY_CHECK_EN
      ,
      .rx_parity_err(rx_parity_err)
`endif
   );

   always #5 clock = ~clock;

   // one s_ticks pulse every 4 clocks -> 64 clocks per bit
   int unsigned tick_div = 0;
   always @(posedge clock) tick_div <= (tick_div == 3) ? 0 : tick_div + 1;
   assign s_ticks = (tick_div == 3);

   int checks = 0;
   int errors = 0;

   int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
   int width_err = 0, excl_err = 0, perr_alone = 0;
   logic prev_done = 1'b0, prev_ferr = 1'b0;
   logic [7:0] got_q[$];

   always @(negedge clock) begin
      if (reset) begin
         prev_done = 1'b0;
         prev_ferr = 1'b0;
      end else begin
         if (rx_done) begin
            done_cnt++;
            got_q.push_back(rx_data_out);
         end
         if (rx_frame_err) ferr_cnt++;
         if ((rx_done && prev_done) || (rx_frame_err && prev_ferr)) width_err++;
         if (rx_done && rx_frame_err) excl_err++;
`ifdef RX_PARITY_CHECK_EN
         if (rx_parity_err) begin
            perr_cnt++;
            if (!rx_done) perr_alone++;
         end
`endif
         prev_done = rx_done;
         prev_ferr = rx_frame_err;
      end
   end

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic send_bit(input logic b, input int clocks);
      @(posedge clock);
      #1 rx_data_in = b;
      repeat (clocks - 1) @(posedge clock);
   endtask

   // a low stop bit is shortened so the trailing low line ends before a false start reaches mid-bit
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      send_bit(1'b0, 64);
      for (int i = 0; i < 8; i++) send_bit(d[i], 64);
      send_bit(par, 64);
      send_bit(stop, stop ? 64 : 48);
      rx_data_in = 1'b1;
   endtask

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      int         exp_done;
      int         exp_ferr;
      logic [7:0] exp_out;
      int         exp_perr;
   } vec_t;

   vec_t vecs[5];
   int   b_done, b_ferr, b_perr, b_q;

   initial begin
      vecs[0] = '{8'hA5, 1'b0, 1'b1, 1, 0, 8'hA5, 0};
      vecs[1] = '{8'h3C, 1'b0, 1'b0, 0, 1, 8'hA5, 0};
      vecs[2] = '{8'h5A, 1'b0, 1'b1, 1, 0, 8'h5A, 0};
      vecs[3] = '{8'h07, 1'b0, 1'b1, 1, 0, 8'h07, 1};
      vecs[4] = '{8'h07, 1'b1, 1'b1, 1, 0, 8'h07, 0};

      rx_data_in = 1'b1;
      reset      = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("reset_data_out", rx_data_out, 0);
      check("reset_done", rx_done, 0);
      check("reset_frame_err", rx_frame_err, 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (20) @(posedge clock);

      for (int v = 0; v < 5; v++) begin
         b_done = done_cnt; b_ferr = ferr_cnt; b_perr = perr_cnt; b_q = got_q.size();
         send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
         send_bit(1'b1, 64);
         check($sformatf("vec%0d_done", v), done_cnt - b_done, vecs[v].exp_done);
         check($sformatf("vec%0d_frame_err", v), ferr_cnt - b_ferr, vecs[v].exp_ferr);
         check($sformatf("vec%0d_data_out", v), rx_data_out, vecs[v].exp_out);
         if (vecs[v].exp_done != 0 && got_q.size() > b_q)
            check($sformatf("vec%0d_data_at_done", v), got_q[got_q.size()-1], vecs[v].exp_out);
`ifdef RX_PARITY_CHECK_EN
         check($sformatf("vec%0d_parity_err", v), perr_cnt - b_perr, vecs[v].exp_perr);
`endif
      end

      // start-bit glitch: 5 ticks low then back high
      b_done = done_cnt; b_ferr = ferr_cnt;
      send_bit(1'b0, 20);
      send_bit(1'b1, 128);
      check("glitch_done", done_cnt - b_done, 0);
      check("glitch_frame_err", ferr_cnt - b_ferr, 0);
      check("glitch_data_out", rx_data_out, 8'h07);

      // back-to-back frames with a single stop bit
      b_done = done_cnt; b_q = got_q.size();
      send_frame(8'h01, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      send_bit(1'b1, 64);
      check("b2b_done", done_cnt - b_done, 2);
      if (got_q.size() >= b_q + 2) begin
         check("b2b_first", got_q[b_q], 8'h01);
         check("b2b_second", got_q[b_q+1], 8'hFF);
      end else begin
         check("b2b_queue_len", got_q.size() - b_q, 2);
      end

      // reset in the middle of the data phase after 3 bits
      send_bit(1'b0, 64);
      send_bit(1'b1, 64);
      send_bit(1'b0, 64);
      send_bit(1'b1, 64);
      send_bit(1'b1, 20);
      reset = 1'b1;
      #1;
      check("midreset_data_out", rx_data_out, 0);
      check("midreset_done", rx_done, 0);
      check("midreset_frame_err", rx_frame_err, 0);
      rx_data_in = 1'b1;
      repeat (4) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      b_done = done_cnt; b_ferr = ferr_cnt; b_q = got_q.size();
      send_bit(1'b1, 64);
      send_frame(8'h5A, 1'b0, 1'b1);
      send_bit(1'b1, 64);
      check("postreset_done", done_cnt - b_done, 1);
      check("postreset_frame_err", ferr_cnt - b_ferr, 0);
      check("postreset_data_out", rx_data_out, 8'h5A);

      check("pulse_width", width_err, 0);
      check("done_ferr_exclusive", excl_err, 0);
`ifdef RX_PARITY_CHECK_EN
      check("parity_err_without_done", perr_alone, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
